// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : traffic_pkg
// Purpose  : Shared FSM encoding, light encodings and timing defaults for the
//            intersection controller and its vehicle request generator.
// Revision : 1.0 - initial release
// ============================================================================
package traffic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQUEST = 2'd1,
    ST_SERVED  = 2'd2,
    ST_FAULT   = 2'd3
  } req_state_t;

  // One-hot {grn, ylw, red} as driven by the light controller
  localparam logic [2:0] LIGHT_GRN = 3'b100;
  localparam logic [2:0] LIGHT_YLW = 3'b010;
  localparam logic [2:0] LIGHT_RED = 3'b001;

  localparam int DEF_DEB_CYCLES   = 50;
  localparam int DEF_STUCK_CYCLES = 60000;
  localparam int DEF_CNT_W        = 16;

endpackage
`default_nettype wire

// File: rtl/loop_debounce.sv
`default_nettype none
// ============================================================================
// Module   : loop_debounce
// Purpose  : Synchronizes the raw loop detector, debounces it and flags a loop
//            that stays occupied for too long.
// Revision : 1.0 - initial release
// ============================================================================
module loop_debounce
  import traffic_pkg::*;
#(
  parameter int DEB_CYCLES   = DEF_DEB_CYCLES,
  parameter int STUCK_CYCLES = DEF_STUCK_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic loop_raw,
  output logic loop_db,
  output logic stuck_det
);

  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam int STK_W = $clog2(STUCK_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [STK_W-1:0] STK_MAX  = STK_W'(STUCK_CYCLES);

  logic             sync_q1;
  logic             loop_s;
  logic [DEB_W-1:0] deb_cnt;
  logic [STK_W-1:0] stk_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      loop_s  <= 1'b0;
      loop_db <= 1'b0;
      deb_cnt <= '0;
      stk_cnt <= '0;
    end else begin
      sync_q1 <= loop_raw;
      loop_s  <= sync_q1;

      // Any sample agreeing with the current level restarts the stability count
      if (loop_s != loop_db) begin
        if (deb_cnt == DEB_LAST) begin
          loop_db <= loop_s;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end

      if (!loop_s) begin
        stk_cnt <= '0;
      end else if (stk_cnt != STK_MAX) begin
        stk_cnt <= stk_cnt + 1'b1;
      end
    end
  end

  assign stuck_det = (stk_cnt >= STK_MAX);

endmodule
`default_nettype wire

// File: rtl/car_request_gen.sv
`default_nettype none
// ============================================================================
// Module   : car_request_gen
// Purpose  : Raises and latches the side-road car request until the light
//            controller acknowledges it; reports wait time and loop faults.
// Revision : 1.0 - initial release
// ============================================================================
module car_request_gen
  import traffic_pkg::*;
#(
  parameter int DEB_CYCLES   = DEF_DEB_CYCLES,
  parameter int STUCK_CYCLES = DEF_STUCK_CYCLES,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             loop_raw,
  input  logic             grn,
  input  logic             ylw,
  input  logic             red,
  output logic             car,
  output logic             served,
  output logic [CNT_W-1:0] wait_cnt,
  output logic             stuck
);

  logic             loop_db;
  logic             stuck_det;
  logic [2:0]       lights;
  logic             green_ok;
  logic             ack;
  req_state_t       state;
  req_state_t       state_nx;
  logic [CNT_W-1:0] wait_nx;

  loop_debounce #(
    .DEB_CYCLES  (DEB_CYCLES),
    .STUCK_CYCLES(STUCK_CYCLES)
  ) u_deb (
    .clk      (clk),
    .rst      (rst),
    .loop_raw (loop_raw),
    .loop_db  (loop_db),
    .stuck_det(stuck_det)
  );

  // Illegal light combinations never count as green
  assign lights   = {grn, ylw, red};
  assign green_ok = (lights == LIGHT_GRN);
  assign ack      = |(lights & (LIGHT_YLW | LIGHT_RED));

  always_comb begin
    state_nx = state;
    wait_nx  = wait_cnt;
    if (state == ST_REQUEST && wait_cnt != '1) begin
      wait_nx = wait_cnt + 1'b1;
    end
    if (stuck_det) begin
      state_nx = ST_FAULT;
    end else begin
      case (state)
        ST_IDLE: begin
          if (loop_db) begin
            state_nx = ST_REQUEST;
            wait_nx  = '0;
          end
        end
        ST_REQUEST: if (ack)                  state_nx = ST_SERVED;
        ST_SERVED:  if (green_ok && !loop_db) state_nx = ST_IDLE;
        ST_FAULT:   if (!loop_db)             state_nx = ST_IDLE;
        default:                              state_nx = ST_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they change with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      car      <= 1'b0;
      served   <= 1'b0;
      stuck    <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
      car      <= (state_nx == ST_REQUEST);
      served   <= (state == ST_REQUEST) && (state_nx == ST_SERVED);
      stuck    <= (state_nx == ST_FAULT);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_car_request_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_car_request_gen
// Purpose  : Directed scenarios plus random loop/light traffic, checked every
//            cycle against a run-length based behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_car_request_gen;

  localparam int DEB   = 4;
  localparam int STK   = 40;
  localparam int CW    = 8;
  localparam int WMAX  = (1 << CW) - 1;
  localparam int M_IDLE = 0, M_REQ = 1, M_SERVED = 2, M_FAULT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          loop_raw = 1'b0;
  logic          grn = 1'b1, ylw = 1'b0, red = 1'b0;
  logic          car, served, stuck;
  logic [CW-1:0] wait_cnt;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  // Model: raw history, run length of the synchronized level, request mode
  int m_s1, m_s2, m_run_val, m_run, m_db, m_mode, m_wait, m_car, m_served, m_stuck;

  car_request_gen #(
    .DEB_CYCLES  (DEB),
    .STUCK_CYCLES(STK),
    .CNT_W       (CW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .loop_raw(loop_raw),
    .grn     (grn),
    .ylw     (ylw),
    .red     (red),
    .car     (car),
    .served  (served),
    .wait_cnt(wait_cnt),
    .stuck   (stuck)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_run_val = 0; m_run = 0; m_db = 0;
    m_mode = M_IDLE; m_wait = 0; m_car = 0; m_served = 0; m_stuck = 0;
  endtask

  task automatic model_edge();
    bit stuck_prev, db_prev, ack, gok;
    stuck_prev = (m_run_val == 1) && (m_run >= STK);
    db_prev    = (m_db == 1);
    ack        = ylw | red;
    gok        = grn & ~ylw & ~red;
    m_served   = 0;
    if (m_mode == M_REQ) m_wait = (m_wait == WMAX) ? WMAX : m_wait + 1;
    if (stuck_prev) begin
      m_mode = M_FAULT;
    end else if (m_mode == M_IDLE && db_prev) begin
      m_mode = M_REQ;
      m_wait = 0;
    end else if (m_mode == M_REQ && ack) begin
      m_mode   = M_SERVED;
      m_served = 1;
    end else if (m_mode == M_SERVED && gok && !db_prev) begin
      m_mode = M_IDLE;
    end else if (m_mode == M_FAULT && !db_prev) begin
      m_mode = M_IDLE;
    end
    m_car   = (m_mode == M_REQ);
    m_stuck = (m_mode == M_FAULT);
    // Debounced level follows the synchronized level once it has held DEB samples
    if (m_s2 == m_run_val) m_run = (m_run < 1000000) ? m_run + 1 : m_run;
    else begin
      m_run_val = m_s2;
      m_run     = 1;
    end
    if (m_run >= DEB) m_db = m_run_val;
    m_s2 = m_s1;
    m_s1 = loop_raw;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_edge();
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_car",      car,      m_car);
      chk("cyc_served",   served,   m_served);
      chk("cyc_wait_cnt", wait_cnt, m_wait);
      chk("cyc_stuck",    stuck,    m_stuck);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    int loop_left, light_left, r;
    rst = 1'b1;
    cyc(3);
    cmp_en = 1;
    chk("rst_car", car, 0);
    chk("rst_wait", wait_cnt, 0);
    rst = 1'b0;
    cyc(2);

    // Request latency: loop_raw first sampled on edge 1, car rises on edge 7
    loop_raw = 1'b1;
    cyc(6);
    chk("car_e6", car, 0);
    cyc(1);
    chk("car_e7", car, 1);
    chk("model_car_e7", m_car, 1);

    // ylw first sampled 11 edges after car rose: REQUEST spans edges 8..18
    cyc(10);
    grn = 1'b0; ylw = 1'b1;
    cyc(1);
    chk("ack_car", car, 0);
    chk("ack_served", served, 1);
    chk("ack_wait", wait_cnt, 11);
    chk("model_wait_11", m_wait, 11);
    cyc(1);
    chk("served_width", served, 0);
    chk("wait_hold", wait_cnt, 11);

    // Back to green with the car still on the loop: no new request
    ylw = 1'b0; red = 1'b1;
    cyc(3);
    red = 1'b0; grn = 1'b1;
    cyc(4);
    chk("no_rereq", car, 0);
    loop_raw = 1'b0;
    cyc(10);
    loop_raw = 1'b1;
    cyc(7);
    chk("rereq_car", car, 1);
    chk("rereq_wait0", wait_cnt, 0);
    cyc(1);
    chk("rereq_wait1", wait_cnt, 1);

    // Loop held: counter reaches 40 on edge 42, FAULT on edge 43
    cyc(34);
    chk("stuck_e42", stuck, 0);
    cyc(1);
    chk("stuck_e43", stuck, 1);
    chk("stuck_car", car, 0);
    chk("stuck_wait", wait_cnt, 36);
    chk("model_stuck_e43", m_stuck, 1);
    cyc(2);
    loop_raw = 1'b0;          // first sampled low on edge 46, loop_s low after 47
    cyc(6);
    chk("stuck_e51", stuck, 1);
    cyc(1);
    chk("stuck_e52", stuck, 0);

    // Short glitch never reaches the debounced level
    cyc(10);
    loop_raw = 1'b1;
    cyc(3);
    loop_raw = 1'b0;
    cyc(15);
    chk("glitch_car", car, 0);

    // Asynchronous reset in REQUEST with wait_cnt = 7
    loop_raw = 1'b1;
    cyc(14);
    chk("pre_rst_wait", wait_cnt, 7);
    rst = 1'b1;
    #1;
    chk("arst_car", car, 0);
    chk("arst_served", served, 0);
    chk("arst_wait", wait_cnt, 0);
    chk("arst_stuck", stuck, 0);
    cyc(2);
    rst = 1'b0;
    cyc(6);
    chk("post_rst_e6", car, 0);
    cyc(1);
    chk("post_rst_e7", car, 1);
    grn = 1'b0; ylw = 1'b1;
    cyc(1);
    chk("post_rst_served", served, 1);
    ylw = 1'b0; grn = 1'b1; loop_raw = 1'b0;
    cyc(12);

    // Latched request with the vehicle gone: wait_cnt saturates
    loop_raw = 1'b1;
    cyc(10);
    loop_raw = 1'b0;
    cyc(300);
    chk("sat_car", car, 1);
    chk("sat_wait", wait_cnt, WMAX);
    grn = 1'b0; ylw = 1'b1;
    cyc(1);
    chk("sat_served", served, 1);
    ylw = 1'b0; grn = 1'b1;
    cyc(12);

    // Random loop occupancy, light sequences (legal and illegal) and resets
    loop_left = 0; light_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (loop_left == 0) begin
        loop_raw  = ~loop_raw;
        loop_left = loop_raw ? int'($urandom_range(1, 55)) : int'($urandom_range(1, 20));
      end
      loop_left--;
      if (light_left == 0) begin
        r = int'($urandom_range(0, 9));
        case (r)
          5:       {grn, ylw, red} = 3'b010;
          6:       {grn, ylw, red} = 3'b001;
          7:       {grn, ylw, red} = 3'b000;
          8:       {grn, ylw, red} = 3'b110;
          9:       {grn, ylw, red} = 3'b111;
          default: {grn, ylw, red} = 3'b100;
        endcase
        light_left = int'($urandom_range(1, 25));
      end
      light_left--;
      rst = ($urandom_range(0, 599) == 0);
      cyc(1);
    end
    rst = 1'b0;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
